// File: rtl/trig_pkg.sv
// Shared types and helpers for the trigger/trigger-ID link transmitter.
package trig_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TRIG   = 3'd1,
    SHIFT  = 3'd2,
    PARITY = 3'd3,
    HOLD   = 3'd4
  } trig_state_t;

  localparam int TRIG_ID_WIDTH_DEFAULT = 16;
  localparam int DROP_CNT_WIDTH        = 16;
  localparam int PARITY_MAX_WIDTH      = 64;

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic even_parity(input logic [PARITY_MAX_WIDTH-1:0] value);
    return ^value;
  endfunction

endpackage

// File: rtl/trig_id_tx_serializer.sv
// trig_id_serializer: parallel-load, MSB-first shift register with a bit counter.
// last_bit is high once every loaded bit has been presented on msb.
module trig_id_serializer #(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             shift,
  output logic             msb,
  output logic             last_bit
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    remaining;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      shreg     <= '0;
      remaining <= '0;
    end else if (load) begin
      shreg     <= load_value;
      remaining <= CW'(WIDTH);
    end else if (shift) begin
      shreg     <= shreg << 1;
      remaining <= remaining - CW'(1);
    end
  end

  assign msb      = shreg[WIDTH-1];
  assign last_bit = (remaining == '0);

endmodule

// File: rtl/trig_id_tx.sv
// trig_id_tx: trigger pulse plus MSB-first serial trigger ID on the 40 MHz link.
// Define TRIG_ID_PARITY_EN to append an even-parity bit after the ID.
//
// state  | meaning
// IDLE   | waiting for an unvetoed trig_req
// TRIG   | trig_out high for TRIG_WIDTH cycles
// SHIFT  | ID bits on trig_id_out, MSB first
// PARITY | even-parity bit of the transmitted ID
// HOLD   | quiet gap before the next request can be accepted
module trig_id_tx
  import trig_pkg::*;
#(
  parameter int ID_WIDTH   = TRIG_ID_WIDTH_DEFAULT,
  parameter int TRIG_WIDTH = 2,
  parameter int HOLDOFF    = 4
) (
  input  logic                      clk_in,
  input  logic                      reset,
  input  logic                      trig_req,
  input  logic                      veto_in,
  input  logic                      id_load,
  input  logic [ID_WIDTH-1:0]       id_load_value,
  output logic                      trig_out,
  output logic                      trig_id_out,
  output logic                      veto_out,
  output logic                      busy,
  output logic [ID_WIDTH-1:0]       tx_id,
  output logic                      tx_done,
  output logic [DROP_CNT_WIDTH-1:0] dropped_count
);
  localparam int TCW = (TRIG_WIDTH > 1) ? $clog2(TRIG_WIDTH) : 1;
  localparam int HCW = (HOLDOFF > 2) ? $clog2(HOLDOFF - 1) : 1;
  localparam logic [TCW-1:0] TRIG_INIT = TCW'(TRIG_WIDTH - 1);
  // The IDLE cycle itself is the last holdoff cycle, so HOLD shows HOLDOFF-1 cycles.
  localparam logic [HCW-1:0] HOLD_INIT = HCW'((HOLDOFF > 1) ? HOLDOFF - 2 : 0);

  trig_state_t       state;
  logic [TCW-1:0]    trig_cnt;
  logic [HCW-1:0]    hold_cnt;
  logic [ID_WIDTH-1:0] id_cnt;
  logic [ID_WIDTH-1:0] tx_value;
  logic              accept;
  logic              drop;
  logic              ser_shift;
  logic              ser_msb;
  logic              ser_last;

  assign accept    = (state == IDLE) && trig_req && !veto_in;
  assign drop      = trig_req && !accept;
  assign tx_value  = id_load ? id_load_value : id_cnt;
  assign ser_shift = ((state == TRIG) && (trig_cnt == '0)) ||
                     ((state == SHIFT) && !ser_last);
  assign busy      = veto_out;

  trig_id_serializer #(
    .WIDTH(ID_WIDTH)
  ) u_ser (
    .clk_in    (clk_in),
    .reset     (reset),
    .load      (accept),
    .load_value(tx_value),
    .shift     (ser_shift),
    .msb       (ser_msb),
    .last_bit  (ser_last)
  );

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state         <= IDLE;
      trig_cnt      <= '0;
      hold_cnt      <= '0;
      id_cnt        <= '0;
      tx_id         <= '0;
      trig_out      <= 1'b0;
      trig_id_out   <= 1'b0;
      veto_out      <= 1'b0;
      tx_done       <= 1'b0;
      dropped_count <= '0;
    end else begin
      tx_done <= 1'b0;

      if (id_load)
        id_cnt <= accept ? id_load_value + ID_WIDTH'(1) : id_load_value;
      else if (accept)
        id_cnt <= id_cnt + ID_WIDTH'(1);

      if (drop && (dropped_count != '1))
        dropped_count <= dropped_count + DROP_CNT_WIDTH'(1);

      case (state)
        IDLE: begin
          if (accept) begin
            state       <= TRIG;
            tx_id       <= tx_value;
            trig_cnt    <= TRIG_INIT;
            trig_out    <= 1'b1;
            trig_id_out <= 1'b0;
            veto_out    <= 1'b1;
          end
        end

        TRIG: begin
          if (trig_cnt == '0) begin
            state       <= SHIFT;
            trig_out    <= 1'b0;
            trig_id_out <= ser_msb;
          end else begin
            trig_cnt <= trig_cnt - TCW'(1);
          end
        end

        SHIFT: begin
          if (!ser_last) begin
            trig_id_out <= ser_msb;
          end else begin
`ifdef TRIG_ID_PARITY_EN
            state       <= PARITY;
            trig_id_out <= even_parity(PARITY_MAX_WIDTH'(tx_id));
`else
            trig_id_out <= 1'b0;
            tx_done     <= 1'b1;
            if (HOLDOFF > 1) begin
              state    <= HOLD;
              hold_cnt <= HOLD_INIT;
            end else begin
              state    <= IDLE;
              veto_out <= 1'b0;
            end
`endif
          end
        end

`ifdef TRIG_ID_PARITY_EN
        PARITY: begin
          trig_id_out <= 1'b0;
          tx_done     <= 1'b1;
          if (HOLDOFF > 1) begin
            state    <= HOLD;
            hold_cnt <= HOLD_INIT;
          end else begin
            state    <= IDLE;
            veto_out <= 1'b0;
          end
        end
`endif

        HOLD: begin
          if (hold_cnt == '0) begin
            state    <= IDLE;
            veto_out <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - HCW'(1);
          end
        end

        default: begin
          state       <= IDLE;
          trig_out    <= 1'b0;
          trig_id_out <= 1'b0;
          veto_out    <= 1'b0;
        end
      endcase
    end
  end

endmodule
